// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Used by the decoder, the hazard unit and the unit itself.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath producing the {hi,lo} result.
// Divides work on magnitudes so the most-negative / -1 case wraps cleanly.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        sgn;
    logic        is_div;
    logic [63:0] ax;
    logic [63:0] bx;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;

    always_comb begin
        sgn      = (md_op == MD_MULT) || (md_op == MD_DIV);
        is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);
        ax       = {{32{sgn & a[31]}}, a};
        bx       = {{32{sgn & b[31]}}, b};
        ma       = (sgn && a[31]) ? -a : a;
        mb       = (sgn && b[31]) ? -b : b;
        div_zero = is_div && (b == 32'd0);
        q        = (b == 32'd0) ? 32'd0 : ma / mb;
        r        = (b == 32'd0) ? 32'd0 : ma % mb;
        result   = 64'd0;
        case (md_op)
            MD_MULT, MD_MULTU: result = ax * bx;
            MD_DIV, MD_DIVU: begin
                result[31:0]  = (sgn && (a[31] ^ b[31])) ? -q : q;
                result[63:32] = (sgn && a[31]) ? -r : r;
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multi-cycle multiply/divide unit with HI/LO registers.
// Results sit in shadows until the countdown ends, so md_out never shows them early.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic [63:0] result;
    logic        div_zero;
    logic        is_md;
    logic        is_div;

    md_arith u_arith (
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .result   (result),
        .div_zero (div_zero)
    );

    always_comb begin
        is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
        is_md  = is_div || (md_op == MD_MULT) || (md_op == MD_MULTU);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (!cancel) begin
                    if (start && is_md) begin
                        res_hi_d = result[63:32];
                        res_lo_d = result[31:0];
                        dz_d     = div_zero;
                        cnt_d    = is_div ? DC : MC;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Divide by zero keeps the architectural HI/LO
                    if (!dz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit.
// Expected HI/LO come from 64-bit integer arithmetic held in the bench.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel_hi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int checks;
    int failures;
    logic [31:0] mhi;
    logic [31:0] mlo;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .cancel (cancel),
        .a      (a),
        .b      (b),
        .sel_hi (sel_hi),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input int op, input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [63:0] cur);
        longint sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        res = cur;
        if (op == 1) res = sx * sy;
        else if (op == 2) res = ux * uy;
        else if (y != 0 && op == 3) begin
            sq = sx / sy;
            sr = sx % sy;
            res = {sr[31:0], sq[31:0]};
        end else if (y != 0 && op == 4) begin
            uq = ux / uy;
            ur = ux % uy;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    task automatic run_op(input string tag, input int op,
                          input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [63:0] e;
        e = model(op, x, y, {mhi, mlo});
        start = 1'b1;
        md_op = 3'(op);
        a = x;
        b = y;
        step();
        start = 1'b0;
        md_op = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            check({tag, "_hidden_hi"}, hi, mhi);
            n++;
            step();
        end
        check({tag, "_busy_cycles"}, 32'(n), (op >= 3) ? 32'd10 : 32'd5);
        mhi = e[63:32];
        mlo = e[31:0];
        check({tag, "_hi"}, hi, mhi);
        check({tag, "_lo"}, lo, mlo);
        check({tag, "_md_out"}, md_out, sel_hi ? mhi : mlo);
    endtask

    task automatic mt(input int op, input logic [31:0] v);
        md_op = 3'(op);
        a = v;
        step();
        md_op = 3'd0;
        if (op == 5) mhi = v;
        else mlo = v;
        check("mt_hi", hi, mhi);
        check("mt_lo", lo, mlo);
    endtask

    initial begin
        int n;
        int op;
        logic [31:0] x, y;
        checks = 0;
        failures = 0;
        mhi = 32'd0;
        mlo = 32'd0;
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        cancel = 1'b0;
        a = 32'd0;
        b = 32'd0;
        sel_hi = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        run_op("mult_neg", 1, 32'hFFFFFFFD, 32'd5);
        check("mult_neg_hi_const", hi, 32'hFFFFFFFF);
        check("mult_neg_lo_const", lo, 32'hFFFFFFF1);
        check("mult_neg_md_const", md_out, 32'hFFFFFFFF);
        sel_hi = 1'b0;
        #1;
        check("md_out_lo", md_out, 32'hFFFFFFF1);
        run_op("multu_max", 2, 32'hFFFFFFFF, 32'd2);
        check("multu_hi_const", hi, 32'h00000001);
        check("multu_lo_const", lo, 32'hFFFFFFFE);
        run_op("div_m7", 3, 32'hFFFFFFF9, 32'd2);
        check("div_lo_const", lo, 32'hFFFFFFFD);
        check("div_hi_const", hi, 32'hFFFFFFFF);
        run_op("div_ovf", 3, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);

        mt(5, 32'h1234);
        mt(6, 32'h5678);
        run_op("divu_zero", 4, 32'd100, 32'd0);
        check("dz_hi_const", hi, 32'h1234);
        check("dz_lo_const", lo, 32'h5678);

        start = 1'b1;
        md_op = 3'd1;
        cancel = 1'b1;
        a = 32'd7;
        b = 32'd9;
        step();
        check("cancel_busy", 32'(busy), 32'd0);
        md_op = 3'd5;
        step();
        start = 1'b0;
        md_op = 3'd6;
        step();
        cancel = 1'b0;
        md_op = 3'd0;
        for (int i = 0; i < 8; i++) begin
            check("cancel_busy_later", 32'(busy), 32'd0);
            step();
        end
        check("cancel_hi", hi, 32'h1234);
        check("cancel_lo", lo, 32'h5678);

        start = 1'b1;
        md_op = 3'd2;
        a = 32'd6;
        b = 32'd7;
        step();
        md_op = 3'd3;
        a = 32'd1000;
        b = 32'd3;
        step();
        md_op = 3'd5;
        step();
        start = 1'b0;
        md_op = 3'd0;
        n = 2;
        while (busy === 1'b1 && n < 50) begin
            n++;
            step();
        end
        check("ignore_cycles", 32'(n), 32'd5);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd42);
        mhi = 32'd0;
        mlo = 32'd42;

        start = 1'b1;
        md_op = 3'd3;
        a = 32'hFFFFFFF9;
        b = 32'd2;
        step();
        start = 1'b0;
        md_op = 3'd0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        for (int i = 0; i < 14; i++) step();
        check("rst_late_hi", hi, 32'd0);
        check("rst_late_lo", lo, 32'd0);
        check("rst_late_busy", 32'(busy), 32'd0);
        mhi = 32'd0;
        mlo = 32'd0;

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(1, 4);
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) y = -y;
            sel_hi = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) mt($urandom_range(5, 6), $urandom);
            run_op("rand", op, x, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage beside the ALU. It accepts one operation per start pulse and holds busy for a fixed latency. It commits the 64-bit result to HI/LO, and drives `md_out`, which the EX/MEM register captures as `Mult_Div` for mfhi/mflo. The hazard unit stalls any md instruction in EX while `start | busy`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle request for mult/multu/div/divu; sampled only when `busy`=0.
- `md_op`  in  3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other codes are none.
- `cancel`  in  1: exception/flush from a later stage; suppresses acceptance this cycle.
- `a`  in  32: rs operand (dividend / multiplicand / mthi-mtlo data).
- `b`  in  32: rt operand.
- `sel_hi`  in  1: `md_out` source, 1 selects HI, 0 selects LO.
- `busy`  out  1: registered; high while an operation is in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.
- `md_out`  out  32: combinational `sel_hi ? hi : lo`.

## Operation
- State: IDLE, RUN. Registers: `cnt` (4 bits), `res_hi`/`res_lo` shadow, `hi`, `lo`, `busy`.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `cnt`=0, state IDLE, shadows 0.
- Accept condition: IDLE and `start` and md_op in {1..4} and !`cancel`.
  - On accept, compute the result from `a`/`b` of that cycle into the shadows.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES, set `busy`=1, go to RUN.
- RUN: `cnt` decrements each cycle.
  - When `cnt`=1: copy shadows to `hi`/`lo`, clear `busy`, return to IDLE.
  - `start`, `mthi`, `mtlo` and `cancel` are ignored in RUN. The hazard unit guarantees none arrive.
- mthi/mtlo: in IDLE with !`cancel`, md_op 5 writes `hi`<=`a` and md_op 6 writes `lo`<=`a` at the edge. `start` is not required for these.
- Arithmetic:
  - mult: `{hi,lo}` = signed 32×32→64.
  - multu: unsigned 32×32→64.
  - div: `lo` = quotient truncated toward zero, `hi` = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (b=0, div or divu): the operation runs the full DIV_CYCLES with `busy` high, then leaves `hi`/`lo` unchanged. A flag bit is latched at accept for this.
- `md_out` always reflects current `hi`/`lo`. A value being computed is never visible.

## Timing
- Accept at edge T: `busy`=1 from T+1.
- mult/multu: `busy` high for cycles T+1..T+5. New `hi`/`lo` and `busy`=0 are visible in cycle T+6.
- div/divu: the same pattern with 10 cycles, so results are visible in T+11.
- Back-to-back operations: a new `start` may be accepted in the first cycle `busy`=0.
- mthi/mtlo: the written value is visible the cycle after the edge.
- `start` together with `cancel`: nothing accepted, `busy` stays 0, and HI/LO are untouched. The same holds for mthi/mtlo with `cancel`.
- `reset` mid-RUN: at the next edge all state returns to reset values and the pending result is discarded. Reset has priority over every other input.

## Structure
- Package `md_pkg`:
  - md_op encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - State enum: IDLE, RUN.
  - Default cycle constants.
  - Shared by the decoder and the hazard unit.
- Sub-module `md_arith`: purely combinational. Takes `md_op`, `a`, `b` and produces a 64-bit `{hi,lo}` result plus a `div_zero` flag. It isolates the signed/unsigned rules for separate unit test.
- The top level holds the FSM, counter, shadows and HI/LO.

## Test plan
- mult a=0xFFFFFFFD (−3), b=5, `sel_hi`=1:
  - `busy` is high exactly 5 cycles.
  - Afterwards `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, and `md_out`=0xFFFFFFFF.
- multu a=0xFFFFFFFF, b=2: `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 cycles.
- div a=−7, b=2: `busy` is high 10 cycles, then `lo`=0xFFFFFFFD and `hi`=0xFFFFFFFF.
- divu a=100, b=0 after mthi 0x1234 and mtlo 0x5678:
  - `busy` is high 10 cycles.
  - Afterwards `hi`=0x1234 and `lo`=0x5678, unchanged.
- `start` (mult) with `cancel`=1: `busy` never rises and `hi`/`lo` are unchanged.
- Ignore and reset cases:
  - A second `start` during RUN has no effect.
  - `reset` asserted at cycle 3 of a div: next cycle `busy`=0, `hi`=`lo`=0, and no later write occurs.
